timealign_nstage: RTL and testbench

Parametrised N-stage time-alignment block for the pipelined converter back end. It generalises the two-stage MSB/LSB aligner to any number of stages and any per-stage width. Each stage's bits are delayed so that all stages belonging to one sample leave together as a single word. Delay lines advance only on valid beats, so gapped input streams stay aligned. A fill counter and a flush input qualify the output.

---
 rtl/timealign_nstage.sv | 59 +++++
 tb/tb_timealign_nstage.sv | 114 +++++++++++
 2 files changed

// File: rtl/timealign_nstage.sv
// timealign_nstage: N-stage converter bit aligner advancing on valid beats; define TIMEALIGN_OUT_REG_EN to register dout_o/dout_valid_o
module timealign_nstage #(
   parameter int NUM_STAGES = 4,
   parameter int BITS_PER_STAGE = 3,
   localparam int DOUT_W = NUM_STAGES * BITS_PER_STAGE
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              valid_i,
   input  logic [DOUT_W-1:0] stage_bits_i,
   input  logic              flush_i,
   output logic [DOUT_W-1:0] dout_o,
   output logic              dout_valid_o,
   output logic              aligned_o
);
   localparam int FW = $clog2(NUM_STAGES);
   localparam logic [FW-1:0] FILL_MAX = FW'(NUM_STAGES - 1);
   logic [FW-1:0] fill;
   logic [DOUT_W-1:0] aligned_word;
   logic [DOUT_W-1:0] dout_c;
   logic valid_c;
   always_ff @(posedge clk_i)
      if (reset_i || flush_i) fill <= '0;
      else if (valid_i && fill != FILL_MAX) fill <= fill + FW'(1);
   assign aligned_o = (fill == FILL_MAX) && !reset_i;
   assign valid_c = valid_i && aligned_o && !flush_i;
   assign dout_c = valid_c ? aligned_word : '0;
   genvar k;
   for (k = 0; k < NUM_STAGES; k++) begin : g_stage
      localparam int D = NUM_STAGES - 1 - k;
      localparam int LSB = (NUM_STAGES - 1 - k) * BITS_PER_STAGE;
      if (D == 0) begin : g_live
         assign aligned_word[LSB +: BITS_PER_STAGE] = stage_bits_i[LSB +: BITS_PER_STAGE];
      end else begin : g_dl
         // earlier stages wait D beats for the last stage of their sample
         logic [BITS_PER_STAGE-1:0] dl [D];
         always_ff @(posedge clk_i)
            if (reset_i || flush_i) dl <= '{default: '0};
            else if (valid_i) begin
               dl[0] <= stage_bits_i[LSB +: BITS_PER_STAGE];
               for (int j = 1; j < D; j++) dl[j] <= dl[j-1];
            end
         assign aligned_word[LSB +: BITS_PER_STAGE] = dl[D-1];
      end
   end
`ifdef TIMEALIGN_OUT_REG_EN
   always_ff @(posedge clk_i)
      if (reset_i || flush_i) begin
         dout_o <= '0;
         dout_valid_o <= 1'b0;
      end else begin
         dout_o <= dout_c;
         dout_valid_o <= valid_c;
      end
`else
   assign dout_o = dout_c;
   assign dout_valid_o = valid_c;
`endif
endmodule

// File: tb/tb_timealign_nstage.sv
// tb_timealign_nstage: directed vectors for the 4-stage and 2-stage aligner
module tb_timealign_nstage;
   typedef struct {
      logic rst, flush, valid;
      logic [11:0] bits;
      logic [11:0] dout;
      logic dv, al;
   } vec_t;
   logic clk_i = 1'b0;
   logic reset_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0;
   logic [11:0] stage_bits_i = '0;
   logic [11:0] dout_o;
   logic dout_valid_o, aligned_o;
   logic reset2 = 1'b1, flush2 = 1'b0, valid2 = 1'b0;
   logic [5:0] bits2 = '0;
   logic [5:0] dout2;
   logic dv2, al2;
   int checks = 0, failures = 0;
   logic [11:0] p_dout [2] = '{12'h0, 12'h0};
   logic p_dv [2] = '{1'b0, 1'b0};
   vec_t tbl [$];
   vec_t seq2 [$];

   always #5 clk_i = ~clk_i;

   timealign_nstage #(.NUM_STAGES(4), .BITS_PER_STAGE(3)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .stage_bits_i(stage_bits_i),
      .flush_i(flush_i), .dout_o(dout_o), .dout_valid_o(dout_valid_o), .aligned_o(aligned_o));

   timealign_nstage #(.NUM_STAGES(2), .BITS_PER_STAGE(3)) dut2 (
      .clk_i(clk_i), .reset_i(reset2), .valid_i(valid2), .stage_bits_i(bits2),
      .flush_i(flush2), .dout_o(dout2), .dout_valid_o(dv2), .aligned_o(al2));

   function automatic vec_t mk(logic rst, logic flush, logic valid, logic [11:0] bits,
                               logic [11:0] dout, logic dv, logic al);
      vec_t v;
      v.rst = rst; v.flush = flush; v.valid = valid; v.bits = bits;
      v.dout = dout; v.dv = dv; v.al = al;
      return v;
   endfunction

   // stage k on beat b carries sample b-k (+off)
   function automatic logic [11:0] beat_bits(int b, int off);
      logic [11:0] r;
      for (int k = 0; k < 4; k++) r[(3-k)*3 +: 3] = 3'(b - k + off);
      return r;
   endfunction

   function automatic logic [11:0] rep(int n);
      logic [2:0] t;
      t = 3'(n);
      return {t, t, t, t};
   endfunction

   task automatic chk(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int idx, input int u);
      logic [11:0] ad, ed;
      logic adv, aal, edv;
      @(negedge clk_i);
      if (u == 0) begin
         reset_i = v.rst; flush_i = v.flush; valid_i = v.valid; stage_bits_i = v.bits;
      end else begin
         reset2 = v.rst; flush2 = v.flush; valid2 = v.valid; bits2 = v.bits[5:0];
      end
      #1;
      ad = (u == 0) ? dout_o : {6'h0, dout2};
      adv = (u == 0) ? dout_valid_o : dv2;
      aal = (u == 0) ? aligned_o : al2;
`ifdef TIMEALIGN_OUT_REG_EN
      ed = p_dout[u]; edv = p_dv[u];
`else
      ed = v.dout; edv = v.dv;
`endif
      p_dout[u] = v.dout; p_dv[u] = v.dv;
      chk(u == 0 ? "n4.dout" : "n2.dout", idx, ad, ed);
      chk(u == 0 ? "n4.dout_valid" : "n2.dout_valid", idx, {11'h0, adv}, {11'h0, edv});
      chk(u == 0 ? "n4.aligned" : "n2.aligned", idx, {11'h0, aal}, {11'h0, v.al});
   endtask

   initial begin
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 1, 12'hFFF, 0, 0, 0));
      for (int b = 1; b <= 8; b++)
         tbl.push_back(mk(0, 0, 1, beat_bits(b, 0), b >= 4 ? rep(b - 3) : 12'h0, b >= 4, b >= 4));
      tbl.push_back(mk(1, 0, 1, 12'hFFF, 0, 0, 0));
      for (int b = 1; b <= 8; b++) begin
         tbl.push_back(mk(0, 0, 1, beat_bits(b, 0), b >= 4 ? rep(b - 3) : 12'h0, b >= 4, b >= 4));
         tbl.push_back(mk(0, 0, 0, 12'hABC, 0, 0, b >= 3));
      end
      tbl.push_back(mk(1, 0, 0, 12'h0, 0, 0, 0));
      for (int b = 1; b <= 6; b++)
         tbl.push_back(mk(0, 0, 1, beat_bits(b, 0), b >= 4 ? rep(b - 3) : 12'h0, b >= 4, b >= 4));
      tbl.push_back(mk(0, 1, 1, 12'h5A5, 0, 0, 1));
      for (int c = 1; c <= 5; c++)
         tbl.push_back(mk(0, 0, 1, beat_bits(c, 4), c >= 4 ? rep(c + 1) : 12'h0, c >= 4, c >= 4));
      tbl.push_back(mk(0, 0, 0, 12'h0, 0, 0, 1));
      seq2.push_back(mk(1, 0, 1, 12'h03F, 0, 0, 0));
      seq2.push_back(mk(0, 0, 1, {6'h0, 3'b101, 3'b000}, 0, 0, 0));
      seq2.push_back(mk(0, 0, 1, {6'h0, 3'b111, 3'b011}, {6'h0, 6'b101011}, 1, 1));
      seq2.push_back(mk(0, 0, 0, 12'h0, 0, 0, 1));
      seq2.push_back(mk(0, 0, 1, {6'h0, 3'b000, 3'b111}, {6'h0, 6'b111111}, 1, 1));
      seq2.push_back(mk(0, 0, 0, 12'h0, 0, 0, 1));
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i, 0);
      for (int i = 0; i < seq2.size(); i++) step(seq2[i], i, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
